rtc_read_scheduler: RTL and testbench

// - Sequences the input register bank of the RTC controller. Periodically, or on request, sweeps the
//   RTC time/date/timer registers: issues one read per address to the RTC bus driver and pulses the

---
 rtl/rtc_ctrl_pkg.sv | 32 +++
 rtl/rtc_read_scheduler_if.sv | 11 +
 rtl/rtc_refresh_timer.sv | 22 ++
 rtl/rtc_read_scheduler.sv | 139 +++++++++++++
 tb/tb_rtc_read_scheduler.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_ctrl_pkg.sv
// Shared constants for the RTC controller input bank: address table, bank
// register indices and read-scheduler FSM states.
package rtc_ctrl_pkg;

    localparam int unsigned N_RTC_REGS    = 9;
    localparam int unsigned N_BANK        = 14;

    localparam int unsigned REG_IRQ       = 0;
    localparam int unsigned REG_READY     = 1;
    localparam int unsigned REG_RTC_FIRST = 2;
    localparam int unsigned REG_KBD       = 11;
    localparam int unsigned REG_NEWDATA   = 12;
    localparam int unsigned REG_CAMBIO    = 13;

    // Entry k is the RTC address whose data lands in bank reg REG_RTC_FIRST+k.
    localparam logic [N_RTC_REGS-1:0][7:0] RTC_ADDR_TABLE = {
        8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_NEXT
    } rd_state_e;

    function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
        rtc_addr = (idx < 4'(N_RTC_REGS)) ? RTC_ADDR_TABLE[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/rtc_read_scheduler_if.sv
// Read handshake between the scheduler (master) and the RTC bus driver (slave).
interface rtc_read_scheduler_if;

    logic       rd_start;
    logic [7:0] rd_addr;
    logic       rd_done;

    modport master (output rd_start, output rd_addr, input rd_done);
    modport slave  (input rd_start, input rd_addr, output rd_done);

endinterface

// File: rtl/rtc_refresh_timer.sv
// Free-running 0..REFRESH_CYCLES-1 counter; o_tick is high on the wrap cycle.
module rtc_refresh_timer #(
    parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int unsigned CW = $clog2(REFRESH_CYCLES);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_cnt <= '0;
        else if (o_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/rtc_read_scheduler.sv
// Sweeps the RTC time/date/timer registers into the input bank and generates
// the status/event bank enables.
module rtc_read_scheduler
    import rtc_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sweep_req,
    input  logic                  inhibit,
    input  logic                  kbd_strobe,
    input  logic                  cambio_strobe,
    input  logic                  err_clr,
    rtc_read_scheduler_if.master  rd,
    output logic [N_BANK-1:0]     en,
    output logic                  busy,
    output logic                  sweep_done,
    output logic                  timeout_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    rd_state_e             r_state;
    logic [3:0]            r_idx;
    logic [TW-1:0]         r_to_cnt;
    logic                  r_pending;
    logic                  r_rd_start;
    logic [7:0]            r_rd_addr;
    logic [N_RTC_REGS-1:0] r_cap_en;
    logic                  r_status_en;
    logic                  r_sweep_done;
    logic                  r_timeout_err;
    logic                  r_kbd_en;
    logic                  r_cambio_en;
    logic                  w_tick;

    rtc_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    // Status enables track "next state is IDLE" so they line up with busy=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_to_cnt      <= '0;
            r_pending     <= 1'b0;
            r_rd_start    <= 1'b0;
            r_rd_addr     <= 8'h00;
            r_cap_en      <= '0;
            r_status_en   <= 1'b0;
            r_sweep_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_rd_start   <= 1'b0;
            r_sweep_done <= 1'b0;
            r_cap_en     <= '0;
            if (w_tick || sweep_req) r_pending <= 1'b1;
            if (err_clr) r_timeout_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (r_pending && !inhibit) begin
                        r_state     <= ST_ISSUE;
                        r_pending   <= 1'b0;
                        r_rd_start  <= 1'b1;
                        r_rd_addr   <= rtc_addr(r_idx);
                        r_status_en <= 1'b0;
                    end else begin
                        r_status_en <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_to_cnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rd.rd_done) begin
                        r_cap_en <= N_RTC_REGS'(1) << r_idx;
                        r_state  <= ST_CAPTURE;
                    end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_NEXT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: r_state <= ST_NEXT;
                ST_NEXT: begin
                    if (r_idx == 4'(N_RTC_REGS - 1)) begin
                        r_sweep_done <= 1'b1;
                        r_idx        <= '0;
                        r_status_en  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_idx      <= r_idx + 4'd1;
                        r_rd_addr  <= rtc_addr(r_idx + 4'd1);
                        r_rd_start <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kbd_en    <= 1'b0;
            r_cambio_en <= 1'b0;
        end else begin
            r_kbd_en    <= kbd_strobe;
            r_cambio_en <= cambio_strobe;
        end
    end

    always_comb begin
        en                                  = '0;
        en[REG_IRQ]                         = r_status_en;
        en[REG_READY]                       = r_status_en;
        en[REG_NEWDATA]                     = r_status_en;
        en[REG_RTC_FIRST +: N_RTC_REGS]     = r_cap_en;
        en[REG_KBD]                         = r_kbd_en;
        en[REG_CAMBIO]                      = r_cambio_en;
    end

    assign rd.rd_start  = r_rd_start;
    assign rd.rd_addr   = r_rd_addr;
    assign busy         = (r_state != ST_IDLE);
    assign sweep_done   = r_sweep_done;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_rtc_read_scheduler.sv
// Directed, table-driven bench for rtc_read_scheduler.
module tb_rtc_read_scheduler;
    import rtc_ctrl_pkg::*;

    localparam int unsigned REFRESH = 300;
    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sweep_req = 1'b0;
    logic        inhibit = 1'b0;
    logic        kbd_strobe = 1'b0;
    logic        cambio_strobe = 1'b0;
    logic        err_clr = 1'b0;
    logic [13:0] en;
    logic        busy;
    logic        sweep_done;
    logic        timeout_err;

    rtc_read_scheduler_if rd_bus ();

    rtc_read_scheduler #(
        .REFRESH_CYCLES (REFRESH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sweep_req     (sweep_req),
        .inhibit       (inhibit),
        .kbd_strobe    (kbd_strobe),
        .cambio_strobe (cambio_strobe),
        .err_clr       (err_clr),
        .rd            (rd_bus),
        .en            (en),
        .busy          (busy),
        .sweep_done    (sweep_done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ans;     // driver answers with rd_done one cycle after rd_start
        logic        kbd;     // kbd_strobe driven alongside rd_done
        logic        cam;     // cambio_strobe driven alongside rd_done
        int          start;   // rd_start cycle relative to the sweep's first rd_start
        logic [7:0]  addr;
        logic [13:0] en_cap;  // en in capture cycle, or in NEXT cycle after a timeout
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] addrs [9];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_start = 0;
    int         n_done = 0;
    int         n_cap [14];
    int         cap_base [14];

    initial for (int b = 0; b < 14; b++) n_cap[b] = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (rd_bus.rd_start) n_start++;
            if (sweep_done) n_done++;
            for (int b = 0; b < 14; b++) if (en[b]) n_cap[b]++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sweep_req = 1'b0;
        inhibit = 1'b0;
        kbd_strobe = 1'b0;
        cambio_strobe = 1'b0;
        err_clr = 1'b0;
        rd_bus.rd_done = 1'b0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    task automatic wait_start(input int limit, output int waited);
        waited = 0;
        while (rd_bus.rd_start !== 1'b1 && waited < limit) begin
            step();
            waited++;
        end
    endtask

    task automatic set_vec(input int i, input logic ans, input logic kbd, input logic cam,
                           input int start, input logic [7:0] addr, input logic [13:0] e);
        vecs[i].ans = ans;  vecs[i].kbd = kbd;  vecs[i].cam = cam;
        vecs[i].start = start;  vecs[i].addr = addr;  vecs[i].en_cap = e;
    endtask

    task automatic pulse_req();
        sweep_req = 1'b1;
        step();
        sweep_req = 1'b0;
    endtask

    // Called one cycle after the sweep_req pulse; applies vecs[] and checks the sweep.
    task automatic run_sweep(input string tag, input int exp_done_rel);
        int t0;
        int w;
        wait_start(4, w);
        check({tag, "_req_latency"}, w, 1);
        t0 = cyc;
        for (int i = 0; i < 9; i++) begin
            wait_start(10, w);
            check($sformatf("%s_start_seen[%0d]", tag, i), rd_bus.rd_start, 1'b1);
            check($sformatf("%s_start_cyc[%0d]", tag, i), cyc - t0, vecs[i].start);
            check($sformatf("%s_addr[%0d]", tag, i), rd_bus.rd_addr, vecs[i].addr);
            if (vecs[i].ans) begin
                step();
                rd_bus.rd_done = 1'b1;
                kbd_strobe = vecs[i].kbd;
                cambio_strobe = vecs[i].cam;
                step();
                rd_bus.rd_done = 1'b0;
                kbd_strobe = 1'b0;
                cambio_strobe = 1'b0;
                check($sformatf("%s_en_cap[%0d]", tag, i), en, vecs[i].en_cap);
            end else begin
                repeat (TIMEOUT) step();
                err_clr = 1'b1;
                step();
                err_clr = 1'b0;
                check($sformatf("%s_en_to[%0d]", tag, i), en, vecs[i].en_cap);
                check($sformatf("%s_to_err_set_wins[%0d]", tag, i), timeout_err, 1'b1);
            end
        end
        w = 0;
        while (sweep_done !== 1'b1 && w < 10) begin
            step();
            w++;
        end
        check({tag, "_done_seen"}, sweep_done, 1'b1);
        check({tag, "_done_cyc"}, cyc - t0, exp_done_rel);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_en"}, en, 14'h1003);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int s0;
        int d0;
        addrs[0] = 8'h21; addrs[1] = 8'h22; addrs[2] = 8'h23;
        addrs[3] = 8'h24; addrs[4] = 8'h25; addrs[5] = 8'h26;
        addrs[6] = 8'h41; addrs[7] = 8'h42; addrs[8] = 8'h43;
        rd_bus.rd_done = 1'b0;

        // Reset state.
        step();
        check("rst_en", en, 14'h0000);
        check("rst_rd_start", rd_bus.rd_start, 1'b0);
        check("rst_rd_addr", rd_bus.rd_addr, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_sweep_done", sweep_done, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        do_reset();
        check("post_rst_en", en, 14'h0000);
        step();
        check("idle_status_en", en, 14'h1003);

        // Full sweep, every read answered; strobes alongside two captures.
        do_reset();
        set_vec(0, 1, 0, 0,  0, 8'h21, 14'h0004);
        set_vec(1, 1, 0, 0,  4, 8'h22, 14'h0008);
        set_vec(2, 1, 0, 0,  8, 8'h23, 14'h0010);
        set_vec(3, 1, 0, 0, 12, 8'h24, 14'h0020);
        set_vec(4, 1, 0, 0, 16, 8'h25, 14'h0040);
        set_vec(5, 1, 1, 1, 20, 8'h26, 14'h2880);
        set_vec(6, 1, 0, 1, 24, 8'h41, 14'h2100);
        set_vec(7, 1, 0, 0, 28, 8'h42, 14'h0200);
        set_vec(8, 1, 0, 0, 32, 8'h43, 14'h0400);
        for (int b = 0; b < 14; b++) cap_base[b] = n_cap[b];
        pulse_req();
        run_sweep("norm", 36);
        check("norm_timeout_err", timeout_err, 1'b0);
        for (int b = 2; b <= 10; b++)
            check($sformatf("norm_cap_count[%0d]", b), n_cap[b] - cap_base[b], 1);

        // Silent driver on 0x23: 4 WAIT cycles, no capture, sweep continues.
        do_reset();
        set_vec(0, 1, 0, 0,  0, 8'h21, 14'h0004);
        set_vec(1, 1, 0, 0,  4, 8'h22, 14'h0008);
        set_vec(2, 0, 0, 0,  8, 8'h23, 14'h0000);
        set_vec(3, 1, 0, 0, 14, 8'h24, 14'h0020);
        set_vec(4, 1, 0, 0, 18, 8'h25, 14'h0040);
        set_vec(5, 1, 0, 0, 22, 8'h26, 14'h0080);
        set_vec(6, 1, 0, 0, 26, 8'h41, 14'h0100);
        set_vec(7, 1, 0, 0, 30, 8'h42, 14'h0200);
        set_vec(8, 1, 0, 0, 34, 8'h43, 14'h0400);
        for (int b = 0; b < 14; b++) cap_base[b] = n_cap[b];
        pulse_req();
        run_sweep("tmo", 38);
        check("tmo_err_sticky", timeout_err, 1'b1);
        check("tmo_no_en4", n_cap[4] - cap_base[4], 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tmo_err_cleared", timeout_err, 1'b0);

        // Inhibit holds off the sweep; stray rd_done in IDLE is ignored.
        do_reset();
        step();
        inhibit = 1'b1;
        s0 = n_start;
        pulse_req();
        rd_bus.rd_done = 1'b1;
        step();
        rd_bus.rd_done = 1'b0;
        repeat (8) step();
        check("inh_no_start", n_start - s0, 0);
        check("inh_busy", busy, 1'b0);
        check("inh_status_en", en, 14'h1003);
        kbd_strobe = 1'b1;
        step();
        kbd_strobe = 1'b0;
        check("inh_kbd_en", en, 14'h1803);
        inhibit = 1'b0;
        step();
        check("inh_release_start", rd_bus.rd_start, 1'b1);
        check("inh_release_addr", rd_bus.rd_addr, 8'h21);
        check("inh_release_en", en, 14'h0000);

        // sweep_req during a sweep at idx 3 yields exactly one more sweep.
        do_reset();
        s0 = n_start;
        d0 = n_done;
        pulse_req();
        for (int k = 0; k < 18; k++) begin
            wait_start(12, w);
            check($sformatf("dbl_start_seen[%0d]", k), rd_bus.rd_start, 1'b1);
            check($sformatf("dbl_addr[%0d]", k), rd_bus.rd_addr, addrs[k % 9]);
            if (k == 3) sweep_req = 1'b1;
            step();
            sweep_req = 1'b0;
            rd_bus.rd_done = 1'b1;
            step();
            rd_bus.rd_done = 1'b0;
        end
        repeat (60) step();
        check("dbl_start_count", n_start - s0, 18);
        check("dbl_done_count", n_done - d0, 2);
        check("dbl_busy_end", busy, 1'b0);

        // Reset mid-WAIT at idx 4; afterwards only the refresh wrap starts a sweep.
        do_reset();
        pulse_req();
        for (int k = 0; k < 4; k++) begin
            wait_start(12, w);
            step();
            rd_bus.rd_done = 1'b1;
            step();
            rd_bus.rd_done = 1'b0;
        end
        wait_start(12, w);
        check("mid_idx4_addr", rd_bus.rd_addr, 8'h25);
        step();
        check("mid_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_en", en, 14'h0000);
        check("mid_rst_rd_start", rd_bus.rd_start, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        repeat (2) step();
        reset = 1'b1;
        wait_start(REFRESH + 10, w);
        check("refresh_start_latency", w, REFRESH + 1);
        check("refresh_addr", rd_bus.rd_addr, 8'h21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
